multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have the following ports:
  Clk  input  1  clock; all state changes on rising edge.
  Reset  input  1  synchronous, active-high reset.
  Instr  input  32  instruction word from IFSTAGE memory.
  ALU_zero  input  1  ALU zero flag from EXSTAGE.
  Mem_Ready  input  1  data memory access complete.
  IR_LdEn  output  1  load instruction register.
  PC_LdEn  output  1  load program counter.
  PC_sel  output  1  0 = PC+4, 1 = PC+4+(Immed<<2).
  RF_WrEn  output  1  register file write enable (to DECSTAGE).
  RF_WrData_sel  output  1  0 = ALU_out, 1 = MEM_out.
  RF_B_sel  output  1  0 = Instr[15:11], 1 = Instr[20:16].
  ALU_Bin_sel  output  1  0 = RF_B, 1 = Immed.
  ALU_func  output  4  ALU operation code.
  MEM_WrEn  output  1  data memory write enable.
  MEM_Req  output  1  data memory access request.
  State  output  3  current FSM state, for debug.
REQ-002 Clock port SHALL be named Clk; reset SHALL be named Reset, synchronous, active-high.

Function
REQ-003 Instruction fields SHALL be: opcode Instr[31:26]; func Instr[5:0].
REQ-004 Opcode decode SHALL be:
  - 100000 R-type; ALU_func = func[3:0].
  - 111000 li: ALU add, Immed.
  - 111001 lui: ALU add, Immed.
  - 110000 addi: ALU add, Immed.
  - 001111 lw.
  - 011111 sw.
  - 010000 beq.
  - 111111 b.
  - Any other opcode is illegal.
REQ-005 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5-7 SHALL go to FETCH on the next edge.
REQ-006 In FETCH, IR_LdEn SHALL be 1 for one cycle; next state DECODE.
REQ-007 In DECODE, RF_B_sel SHALL be 1 for sw and beq, else 0; next state:
  - EXEC for legal opcodes.
  - FETCH with PC_LdEn=1, PC_sel=0 for an illegal opcode; no RF/MEM write.
REQ-008 In EXEC:
  - ALU_Bin_sel SHALL be 1 for li/lui/addi/lw/sw, else 0.
  - ALU_func SHALL be add (0000) for lw/sw and sub (0001) for beq.
REQ-009 From EXEC:
  - R-type/li/lui/addi SHALL go to WB; lw/sw SHALL go to MEM.
  - beq/b SHALL go to FETCH with PC_LdEn=1.
  - PC_sel SHALL be 1 for b, or for beq with ALU_zero=1; otherwise 0.
REQ-010 In MEM, MEM_Req SHALL be 1 and MEM_WrEn SHALL be 1 only for sw; the state SHALL hold while Mem_Ready=0.
REQ-011 When Mem_Ready=1 in MEM:
  - lw SHALL go to WB.
  - sw SHALL go to FETCH with PC_LdEn=1, PC_sel=0.
REQ-012 In WB:
  - RF_WrEn SHALL be 1 for exactly one cycle.
  - RF_WrData_sel SHALL be 1 for lw, else 0.
  - PC_LdEn=1, PC_sel=0; next state FETCH.
REQ-013 Latency SHALL be:
  - R/li/lui/addi: 4 cycles.
  - lw: 5+W cycles; sw: 4+W cycles (W = MEM wait cycles).
  - beq/b: 3 cycles.
  - Illegal opcode: 2 cycles.
REQ-014 PC_LdEn SHALL be 1 in exactly one cycle per instruction; RF_WrEn and MEM_WrEn SHALL never be 1 in the same cycle.
REQ-015 Outputs SHALL be registered-state Moore decodes, except PC_sel in EXEC, which depends on ALU_zero.
REQ-016 Decode SHALL use the instruction register value latched at FETCH; Instr changes after FETCH SHALL NOT alter sequencing.

Reset
REQ-017 While Reset=1, at each edge:
  - State SHALL go to FETCH.
  - All enables (IR_LdEn, PC_LdEn, RF_WrEn, MEM_WrEn, MEM_Req) SHALL be 0.
  - Select outputs SHALL be 0; ALU_func SHALL be 0000.
REQ-018 Reset asserted mid-instruction (including in MEM with Mem_Ready=0) SHALL abort it with no RF or MEM write in the following cycle.
REQ-019 The first cycle after Reset deasserts SHALL be FETCH with IR_LdEn=1.

Verification
REQ-020 Instr=32'h80230830 (add, func 110000), Reset then released -> States 0,1,2,4,0; RF_WrEn=1 only in WB; RF_WrData_sel=0; ALU_func=0000.
REQ-021 lw (opcode 001111), Mem_Ready held 0 for 3 cycles -> MEM held 4 cycles with MEM_Req=1 and MEM_WrEn=0; then WB with RF_WrData_sel=1; total 8 cycles.
REQ-022 beq (opcode 010000) with ALU_zero=1 in EXEC -> PC_LdEn=1, PC_sel=1; with ALU_zero=0 -> PC_sel=0; RF_WrEn=0 throughout; 3 cycles.
REQ-023 sw (opcode 011111), Mem_Ready=1 immediately -> RF_B_sel=1 in DECODE; MEM_WrEn=1 for one cycle; no RF_WrEn; 4 cycles.
REQ-024 Illegal opcode 000001 -> FETCH, DECODE, FETCH; only PC_LdEn asserted.
REQ-025 Reset=1 asserted during MEM of sw with Mem_Ready=0 -> next State=0, MEM_WrEn=0, MEM_Req=0.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: five-state FETCH/DECODE/EXEC/MEM/WB sequencer for a multicycle datapath
module multicycle_control (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        ALU_zero,
  input  logic        Mem_Ready,
  output logic        IR_LdEn,
  output logic        PC_LdEn,
  output logic        PC_sel,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        MEM_WrEn,
  output logic        MEM_Req,
  output logic [2:0]  State
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
  state_t st;
  logic [5:0] op;
  logic [3:0] fn;
  logic is_r, is_imm, is_lw, is_sw, is_beq, is_b, legal, run, unused_bits;
  assign unused_bits = ^{Instr[25:4]};
  assign is_r   = op == 6'b100000;
  assign is_imm = op == 6'b111000 || op == 6'b111001 || op == 6'b110000;
  assign is_lw  = op == 6'b001111;
  assign is_sw  = op == 6'b011111;
  assign is_beq = op == 6'b010000;
  assign is_b   = op == 6'b111111;
  assign legal  = is_r || is_imm || is_lw || is_sw || is_beq || is_b;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st <= FETCH;
      op <= '0;
      fn <= '0;
    end else begin
      case (st)
        FETCH: begin
          op <= Instr[31:26];
          fn <= Instr[3:0];
          st <= DECODE;
        end
        DECODE:  st <= legal ? EXEC : FETCH;
        EXEC:    st <= (is_lw || is_sw) ? MEM : (is_beq || is_b) ? FETCH : WB;
        MEM:     st <= !Mem_Ready ? MEM : is_lw ? WB : FETCH;
        WB:      st <= FETCH;
        default: st <= FETCH;
      endcase
    end
  end
  // Reset masks every output immediately so an aborted MEM/WB cycle never writes
  assign run           = !Reset;
  assign State         = st;
  assign IR_LdEn       = run && st == FETCH;
  assign PC_LdEn       = run && ((st == DECODE && !legal) || (st == EXEC && (is_beq || is_b)) ||
                                 (st == MEM && Mem_Ready && is_sw) || st == WB);
  assign PC_sel        = run && st == EXEC && (is_b || (is_beq && ALU_zero));
  assign RF_WrEn       = run && st == WB;
  assign RF_WrData_sel = run && st == WB && is_lw;
  assign RF_B_sel      = run && st == DECODE && (is_sw || is_beq);
  assign ALU_Bin_sel   = run && st == EXEC && (is_imm || is_lw || is_sw);
  assign ALU_func      = !(run && st == EXEC) ? 4'b0000 : is_r ? fn : is_beq ? 4'b0001 : 4'b0000;
  assign MEM_Req       = run && st == MEM;
  assign MEM_WrEn      = MEM_Req && is_sw;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-cycle checks of the multicycle control FSM
module tb_multicycle_control;
  logic Clk = 0, Reset = 1, ALU_zero = 0, Mem_Ready = 0;
  logic [31:0] Instr = 32'h80230830;
  logic IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel, MEM_WrEn, MEM_Req;
  logic [3:0] ALU_func;
  logic [2:0] State;
  int vectors = 0, miscompares = 0;
  multicycle_control dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .ALU_zero(ALU_zero), .Mem_Ready(Mem_Ready),
    .IR_LdEn(IR_LdEn), .PC_LdEn(PC_LdEn), .PC_sel(PC_sel), .RF_WrEn(RF_WrEn),
    .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel),
    .ALU_func(ALU_func), .MEM_WrEn(MEM_WrEn), .MEM_Req(MEM_Req), .State(State)
  );
  always #5 Clk = ~Clk;
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  // fields: state, IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel, ALU_func, MEM_WrEn, MEM_Req
  task automatic chk(input string tag, input logic [2:0] s, input logic il, pl, ps, rw, rd, rb, ab,
                     input logic [3:0] af, input logic mw, mr);
    logic [15:0] obs, exp;
    #1;
    obs = {State, IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel, ALU_func, MEM_WrEn, MEM_Req};
    exp = {s, il, pl, ps, rw, rd, rb, ab, af, mw, mr};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    tick;
    tick;
    chk("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    Reset = 0;
    chk("add_fetch", 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick;
    Instr = 32'h04000000;
    chk("add_decode", 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick;
    chk("add_exec", 2, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick;
    chk("add_wb", 4, 0, 1, 0, 1, 0, 0, 0, 4'h0, 0, 0);
    tick;
    Instr = 32'h80000022;
    chk("sub_fetch", 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick;
    tick;
    chk("sub_exec", 2, 0, 0, 0, 0, 0, 0, 0, 4'h2, 0, 0);
    tick;
    chk("sub_wb", 4, 0, 1, 0, 1, 0, 0, 0, 4'h0, 0, 0);
    tick;
    Instr = 32'h3C000000;
    chk("lw_fetch", 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick;
    chk("lw_decode", 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick;
    chk("lw_exec", 2, 0, 0, 0, 0, 0, 0, 1, 4'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("lw_mem_wait", 3, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    end
    tick;
    Mem_Ready = 1;
    chk("lw_mem_ready", 3, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    tick;
    Mem_Ready = 0;
    chk("lw_wb", 4, 0, 1, 0, 1, 1, 0, 0, 4'h0, 0, 0);
    tick;
    Instr = 32'h40000000;
    ALU_zero = 1;
    chk("beq_t_fetch", 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick;
    chk("beq_t_decode", 1, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0);
    tick;
    chk("beq_t_exec", 2, 0, 1, 1, 0, 0, 0, 0, 4'h1, 0, 0);
    tick;
    ALU_zero = 0;
    chk("beq_n_fetch", 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick;
    tick;
    chk("beq_n_exec", 2, 0, 1, 0, 0, 0, 0, 0, 4'h1, 0, 0);
    tick;
    Instr = 32'hFC000000;
    chk("b_fetch", 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick;
    tick;
    chk("b_exec", 2, 0, 1, 1, 0, 0, 0, 0, 4'h0, 0, 0);
    tick;
    Instr = 32'h7C000000;
    Mem_Ready = 1;
    chk("sw_fetch", 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick;
    chk("sw_decode", 1, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0);
    tick;
    chk("sw_exec", 2, 0, 0, 0, 0, 0, 0, 1, 4'h0, 0, 0);
    tick;
    chk("sw_mem", 3, 0, 1, 0, 0, 0, 0, 0, 4'h0, 1, 1);
    tick;
    Mem_Ready = 0;
    Instr = 32'hC0000000;
    chk("addi_fetch", 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick;
    tick;
    chk("addi_exec", 2, 0, 0, 0, 0, 0, 0, 1, 4'h0, 0, 0);
    tick;
    chk("addi_wb", 4, 0, 1, 0, 1, 0, 0, 0, 4'h0, 0, 0);
    tick;
    Instr = 32'h04000000;
    chk("ill_fetch", 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick;
    chk("ill_decode", 1, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick;
    Instr = 32'h7C000000;
    chk("ill_back_fetch", 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick;
    tick;
    tick;
    chk("sw_abort_mem", 3, 0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 1);
    Reset = 1;
    tick;
    chk("sw_abort_reset", 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    Reset = 0;
    chk("post_reset_fetch", 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick;
    chk("post_reset_decode", 1, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
